// File: rtl/nn_pkg.sv
// Shared types and constants for the layer-feeding datapath blocks.
package nn_pkg;
  typedef enum logic {SER_IDLE, SER_STREAM} ser_state_t;
  localparam int UNDERRUN_CNT_W = 16;
endpackage

// File: rtl/input_serializer_pingpong_buf.sv
// Two-bank vector store: writes fill banks alternately, the reader releases them in the same order.
// A bank only accepts data while empty, so a full buffer never overwrites a vector.
module pingpong_buf #(
  parameter int IN_SIZE  = 3,
  parameter int BIT_SIZE = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_en_i,
  input  logic [IN_SIZE-1:0][BIT_SIZE-1:0]  wr_data_i,
  input  logic                              rd_release_i,
  output logic                              wr_ready_o,
  output logic                              rd_full_o,
  output logic [IN_SIZE-1:0][BIT_SIZE-1:0]  rd_data_o
);
  logic [1:0][IN_SIZE-1:0][BIT_SIZE-1:0] bank_q;
  logic [1:0] full_q, full_d;
  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  logic       wr_fire;

  assign wr_ready_o = !full_q[wr_bank_q];
  assign wr_fire    = wr_en_i && wr_ready_o;
  assign rd_full_o  = full_q[rd_bank_q];
  assign rd_data_o  = bank_q[rd_bank_q];

  // Write and release always hit different banks, so both updates can apply together.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    if (wr_fire) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end
    if (rd_release_i) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) bank_q[wr_bank_q] <= wr_data_i;
  end
endmodule

// File: rtl/input_serializer.sv
// Parallel-in, serial-out feeder for a layer stage: element k of a frame appears k+1 cycles after frame_start.
// Optional saturating underrun counter port when INPUT_SERIALIZER_UNDERRUN_CNT_EN is defined.
module input_serializer
  import nn_pkg::*;
#(
  parameter int IN_SIZE  = 3,
  parameter int BIT_SIZE = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [IN_SIZE-1:0][BIT_SIZE-1:0]  in_data,
  input  logic                              frame_start,
  output logic [BIT_SIZE-1:0]               x,
  output logic                              x_valid,
  output logic                              x_last,
  output logic                              underrun,
  output logic                              frame_err
`ifdef INPUT_SERIALIZER_UNDERRUN_CNT_EN
  ,
  output logic [UNDERRUN_CNT_W-1:0]         underrun_cnt
`endif
);
  localparam int                IDX_W    = $clog2(IN_SIZE);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(IN_SIZE - 1);

  ser_state_t                         state_q, state_d;
  logic [IDX_W-1:0]                   idx_q, idx_d;
  logic [BIT_SIZE-1:0]                x_q, x_d;
  logic                               x_valid_q, x_valid_d;
  logic                               x_last_q, x_last_d;
  logic                               underrun_q, underrun_d;
  logic                               frame_err_q, frame_err_d;
  logic                               rd_release;
  logic                               rd_full;
  logic [IN_SIZE-1:0][BIT_SIZE-1:0]   rd_data;

  pingpong_buf #(.IN_SIZE(IN_SIZE), .BIT_SIZE(BIT_SIZE)) u_buf (
    .clk          (clk),
    .rst          (rst),
    .wr_en_i      (in_valid),
    .wr_data_i    (in_data),
    .rd_release_i (rd_release),
    .wr_ready_o   (in_ready),
    .rd_full_o    (rd_full),
    .rd_data_o    (rd_data)
  );

  // Element 0 is registered on the start edge itself, so STREAM covers elements 1..IN_SIZE-1.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    x_d         = '0;
    x_valid_d   = 1'b0;
    x_last_d    = 1'b0;
    underrun_d  = 1'b0;
    frame_err_d = 1'b0;
    rd_release  = 1'b0;
    case (state_q)
      SER_IDLE: begin
        if (frame_start) begin
          if (rd_full) begin
            x_d       = rd_data[0];
            x_valid_d = 1'b1;
            idx_d     = IDX_W'(1);
            state_d   = SER_STREAM;
          end else begin
            underrun_d = 1'b1;
          end
        end
      end
      SER_STREAM: begin
        x_d         = rd_data[idx_q];
        x_valid_d   = 1'b1;
        frame_err_d = frame_start;
        if (idx_q == LAST_IDX) begin
          x_last_d   = 1'b1;
          rd_release = 1'b1;
          idx_d      = '0;
          state_d    = SER_IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = SER_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SER_IDLE;
      idx_q       <= '0;
      x_q         <= '0;
      x_valid_q   <= 1'b0;
      x_last_q    <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      x_q         <= x_d;
      x_valid_q   <= x_valid_d;
      x_last_q    <= x_last_d;
      underrun_q  <= underrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign x         = x_q;
  assign x_valid   = x_valid_q;
  assign x_last    = x_last_q;
  assign underrun  = underrun_q;
  assign frame_err = frame_err_q;

`ifdef INPUT_SERIALIZER_UNDERRUN_CNT_EN
  logic [UNDERRUN_CNT_W-1:0] underrun_cnt_q;

  // Counts on the next-state strobe so the count lands with the pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_cnt_q <= '0;
    end else if (underrun_d && (underrun_cnt_q != {UNDERRUN_CNT_W{1'b1}})) begin
      underrun_cnt_q <= underrun_cnt_q + 1'b1;
    end
  end

  assign underrun_cnt = underrun_cnt_q;
`endif
endmodule

// File: tb/tb_input_serializer.sv
// Scoreboard bench for input_serializer (IN_SIZE=3, BIT_SIZE=8): stimulus queues expected outputs, a monitor checks them.
module tb_input_serializer;
  import nn_pkg::*;

  typedef struct {
    int         cyc;
    logic [7:0] x;
    logic       last;
  } xexp_t;

  typedef struct {
    int cyc;
    int kind;
  } pexp_t;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0][7:0]  in_data;
  logic             frame_start;
  logic [7:0]       x;
  logic             x_valid;
  logic             x_last;
  logic             underrun;
  logic             frame_err;
`ifdef INPUT_SERIALIZER_UNDERRUN_CNT_EN
  logic [UNDERRUN_CNT_W-1:0] underrun_cnt;
`endif

  input_serializer #(.IN_SIZE(3), .BIT_SIZE(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .frame_start (frame_start),
    .x           (x),
    .x_valid     (x_valid),
    .x_last      (x_last),
    .underrun    (underrun),
    .frame_err   (frame_err)
`ifdef INPUT_SERIALIZER_UNDERRUN_CNT_EN
    ,
    .underrun_cnt(underrun_cnt)
`endif
  );

  xexp_t xq[$];
  pexp_t pq[$];
  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pulse_check(input int kind);
    pexp_t p;
    if (pq.size() == 0) begin
      check(kind == 0 ? "underrun_spurious" : "frame_err_spurious", 1, 0);
    end else begin
      p = pq.pop_front();
      check("pulse_cycle", cyc, p.cyc);
      check("pulse_kind", kind, p.kind);
    end
  endtask

  // Monitor: sample on the falling edge, away from the active edge.
  xexp_t e;
  always @(negedge clk) begin
    if (x_valid) begin
      if (xq.size() == 0) begin
        check("x_valid_spurious", 1, 0);
      end else begin
        e = xq.pop_front();
        check("x_cycle", cyc, e.cyc);
        check("x_data", x, e.x);
        check("x_last", x_last, e.last);
      end
    end else begin
      check("x_idle_zero", {x_last, x}, 0);
    end
    if (underrun)  pulse_check(0);
    if (frame_err) pulse_check(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [23:0] v);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = v;
    while (!in_ready && n < 50) begin
      step;
      n++;
    end
    if (n >= 50) check("push_timeout", 1, 0);
    step;
    in_valid = 1'b0;
  endtask

  // nexp: how many elements of v are expected on x; kind: pulse expected on the start edge (-1 none).
  task automatic start_frame(input logic [23:0] v, input int nexp, input int kind);
    int t;
    t = cyc + 1;
    if (nexp > 0) xq.push_back('{t,     v[7:0],   1'b0});
    if (nexp > 1) xq.push_back('{t + 1, v[15:8],  1'b0});
    if (nexp > 2) xq.push_back('{t + 2, v[23:16], 1'b1});
    if (kind >= 0) pq.push_back('{t, kind});
    frame_start = 1'b1;
    step;
    frame_start = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    frame_start = 1'b0;
    step;
    step;
    check("rst_x", x, 0);
    check("rst_x_valid", x_valid, 0);
    check("rst_x_last", x_last, 0);
    check("rst_underrun", underrun, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    step;

    // Single vector
    push(24'h030201);
    start_frame(24'h030201, 3, -1);
    repeat (4) step;
    check("single_in_ready", in_ready, 1);

    // Ping-pong with C held on in_valid while both banks are full
    push(24'h030201);
    push(24'h131211);
    check("both_full_in_ready", in_ready, 0);
    in_valid = 1'b1;
    in_data  = 24'h232221;
    start_frame(24'h030201, 3, -1);
    check("stream_a0_in_ready", in_ready, 0);
    step;
    check("stream_a1_in_ready", in_ready, 0);
    step;
    check("released_in_ready", in_ready, 1);
    start_frame(24'h131211, 3, -1);
    in_valid = 1'b0;
    check("c_accepted_in_ready", in_ready, 0);
    step;
    step;
    start_frame(24'h232221, 3, -1);
    repeat (4) step;

    // Underrun
    check("empty_in_ready", in_ready, 1);
    start_frame(24'h0, 0, 0);
    step;
`ifdef INPUT_SERIALIZER_UNDERRUN_CNT_EN
    check("underrun_cnt_1", underrun_cnt, 1);
`endif

    // Overlapping frame_start
    push(24'h333231);
    push(24'h434241);
    start_frame(24'h333231, 3, -1);
    start_frame(24'h0, 0, 1);
    repeat (3) step;
    start_frame(24'h434241, 3, -1);
    repeat (4) step;

    // Reset mid-stream
    push(24'h535251);
    start_frame(24'h535251, 1, -1);
    step;
    rst = 1'b1;
    #1;
    check("midrst_x_valid", x_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    step;
    rst = 1'b0;
    step;
    start_frame(24'h0, 0, 0);
    step;
`ifdef INPUT_SERIALIZER_UNDERRUN_CNT_EN
    check("underrun_cnt_after_rst", underrun_cnt, 1);
`endif
    repeat (3) step;

    check("x_queue_drained", xq.size(), 0);
    check("pulse_queue_drained", pq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
